// File: rtl/traffic_light.sv
// Highway / country-road intersection controller (Moore FSM, synchronous active-low reset).
// Define TRAFFIC_LIGHT_MIN_GREEN_EN to enforce a minimum highway green time of MIN_HW_GREEN cycles.
module traffic_light #(
  parameter int unsigned Y2R_DELAY    = 3,
  parameter int unsigned R2G_DELAY    = 2,
  parameter int unsigned MIN_HW_GREEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] highway,
  output logic [1:0] cross_road
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // highway green, cross red
    S1 = 3'd1,  // highway yellow
    S2 = 3'd2,  // all red
    S3 = 3'd3,  // cross green
    S4 = 3'd4   // cross yellow
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [3:0] Y2R_LAST = 4'(Y2R_DELAY - 1);
  localparam logic [3:0] R2G_LAST = 4'(R2G_DELAY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       green_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (state == S1 || state == S2 || state == S4)
        cnt <= cnt + 4'd1;
      else
        cnt <= '0;
    end
  end

`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
  localparam logic [3:0] MIN_SAT = 4'(MIN_HW_GREEN);

  // Counts completed highway-green cycles since S0 entry; held at zero elsewhere.
  logic [3:0] gcnt;

  always_ff @(posedge clk) begin
    if (!rst)
      gcnt <= '0;
    else if (state == S0 && state_next == S0) begin
      if (gcnt != MIN_SAT)
        gcnt <= gcnt + 4'd1;
    end else
      gcnt <= '0;
  end

  // The current cycle counts toward the minimum, so leave at the edge that completes it.
  assign green_done = ({1'b0, gcnt} + 5'd1) >= 5'(MIN_HW_GREEN);
`else
  // Minimum-green hold is compiled out; a request is served on the first S0 edge.
  assign green_done = 1'b1 | (MIN_HW_GREEN == 0);
`endif

  // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
  always_comb begin
    state_next = S0;
    case (state)
      S0:      state_next = (x && green_done) ? S1 : S0;
      S1:      state_next = (cnt == Y2R_LAST) ? S2 : S1;
      S2:      state_next = (cnt == R2G_LAST) ? S3 : S2;
      S3:      state_next = x ? S3 : S4;
      S4:      state_next = (cnt == Y2R_LAST) ? S0 : S4;
      default: state_next = S0;
    endcase
  end

  always_comb begin
    highway    = GREEN;
    cross_road = RED;
    case (state)
      S0:      begin highway = GREEN;  cross_road = RED;    end
      S1:      begin highway = YELLOW; cross_road = RED;    end
      S2:      begin highway = RED;    cross_road = RED;    end
      S3:      begin highway = RED;    cross_road = GREEN;  end
      S4:      begin highway = RED;    cross_road = YELLOW; end
      default: begin highway = GREEN;  cross_road = RED;    end
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Self-checking bench for traffic_light: light-level reference model plus directed literal checks.
module tb_traffic_light;

  localparam int Y2R = 3;
  localparam int R2G = 2;
  localparam int MING = 4;

  localparam int RED = 0, YEL = 1, GRN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic [1:0] highway;
  logic [1:0] cross_road;

  int n_checks = 0;
  int n_pass   = 0;

  traffic_light #(
    .Y2R_DELAY   (Y2R),
    .R2G_DELAY   (R2G),
    .MIN_HW_GREEN(MING)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .highway   (highway),
    .cross_road(cross_road)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Reference model: tracks what each road shows and how long the current lights have been up.
  int m_hw, m_cr, t_in;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_hw = GRN; m_cr = RED; t_in = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_hw == GRN) begin
`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
        if (x && (t_in + 1 >= MING)) begin m_hw = YEL; t_in = 0; end
`else
        if (x) begin m_hw = YEL; t_in = 0; end
`endif
        else t_in++;
      end else if (m_hw == YEL) begin
        t_in++;
        if (t_in == Y2R) begin m_hw = RED; t_in = 0; end
      end else if (m_cr == RED) begin
        t_in++;
        if (t_in == R2G) begin m_cr = GRN; t_in = 0; end
      end else if (m_cr == GRN) begin
        if (!x) begin m_cr = YEL; t_in = 0; end
      end else begin
        t_in++;
        if (t_in == Y2R) begin m_cr = RED; m_hw = GRN; t_in = 0; end
      end
    end
  end

  // Every-cycle comparison against the model plus encoding/safety properties.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_hw", int'(highway), m_hw);
      check("model_cr", int'(cross_road), m_cr);
      check("no_code3", int'(highway == 2'd3 || cross_road == 2'd3), 0);
      check("one_non_red", int'(highway != 2'd0 && cross_road != 2'd0), 0);
    end
  end

  // Apply inputs for the next edge, then check the lights that edge produced.
  task automatic tick(input logic r, input logic xi, input int exp_hw, input int exp_cr,
                      input string name);
    rst = r;
    x   = xi;
    @(negedge clk);
    check({name, "_hw"}, int'(highway), exp_hw);
    check({name, "_cr"}, int'(cross_road), exp_cr);
  endtask

  initial begin
    rst = 1'b0;
    x   = 1'b1;
    @(negedge clk);
    tick(1'b0, 1'b1, GRN, RED, "rst_hold");

`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, GRN, RED, "min_green");
    tick(1'b1, 1'b1, YEL, RED, "min_green_exit");
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, YEL, RED, "min_y");
    for (int i = 0; i < R2G; i++) tick(1'b1, 1'b1, RED, RED, "min_allred");
    tick(1'b1, 1'b1, RED, GRN, "min_cross_green");
`else
    // Full cycle: cross green 6 edges after the request is sampled.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, YEL, RED, "full_y");
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, RED, RED, "full_allred");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, RED, GRN, "full_cross_green");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, RED, YEL, "full_cross_y");
    tick(1'b1, 1'b0, GRN, RED, "full_back");

    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, GRN, RED, "idle");

    // One-cycle request still runs the whole sequence; S3 lasts a single cycle.
    tick(1'b1, 1'b1, YEL, RED, "short_y0");
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, YEL, RED, "short_y");
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, RED, RED, "short_allred");
    tick(1'b1, 1'b0, RED, GRN, "short_s3");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, RED, YEL, "short_cross_y");
    tick(1'b1, 1'b0, GRN, RED, "short_back");

    // Reset in the all-red phase, then a fresh request yellows for the full 3 cycles.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, YEL, RED, "mid_y");
    tick(1'b1, 1'b0, RED, RED, "mid_allred");
    tick(1'b0, 1'b0, GRN, RED, "mid_reset");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, YEL, RED, "post_rst_y");
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, RED, RED, "post_rst_allred");
    tick(1'b1, 1'b1, RED, GRN, "post_rst_green");

    // Re-request during cross yellow does not abort it; S1 follows one edge after S0.
    tick(1'b1, 1'b0, RED, YEL, "s4_y0");
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, RED, YEL, "s4_rereq");
    tick(1'b1, 1'b1, GRN, RED, "s4_back");
    tick(1'b1, 1'b1, YEL, RED, "s4_reenter");
`endif

    // Randomised traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) x = ~x;
      rst = ($urandom_range(60) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
